// File: rtl/chirp_spi_pkg.sv
// Shared definitions for the chirp multi-device SPI master: FSM encoding, default widths, mode bits.
package chirp_spi_pkg;

  localparam int DEF_NUM_DEV  = 2;
  localparam int DEF_MAX_BITS = 32;
  localparam int DEF_DIV_W    = 16;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LEAD   = 3'd1;
  localparam logic [2:0] ST_EDGE_A = 3'd2;
  localparam logic [2:0] ST_EDGE_B = 3'd3;
  localparam logic [2:0] ST_TRAIL  = 3'd4;
  localparam logic [2:0] ST_DONE   = 3'd5;

  localparam logic CPOL_IDLE_LOW    = 1'b0;
  localparam logic CPOL_IDLE_HIGH   = 1'b1;
  localparam logic CPHA_SAMPLE_LEAD = 1'b0;
  localparam logic CPHA_SHIFT_LEAD  = 1'b1;

endpackage

// File: rtl/chirp_spi_clkgen.sv
// Half-period timer for the chirp SPI master: tick_o marks the last clock of each (div_i+1)-clock phase.
module chirp_spi_clkgen
  import chirp_spi_pkg::*;
#(
  parameter int DIV_W = DEF_DIV_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear_i,
  input  logic             en_i,
  input  logic [DIV_W-1:0] div_i,
  output logic             tick_o
);

  logic [DIV_W-1:0] cnt_q, cnt_d;

  assign tick_o = en_i && (cnt_q == div_i);

  // NOTE: every signal written in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i || tick_o) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + DIV_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so all registers update together on the edge.
  always_ff @(posedge clock) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/chirp_spi_master_multi.sv
// Multi-device SPI master with per-transfer CPOL/CPHA; define CHIRP_SPI_READBACK_EN to add miso capture
// (ports miso/rd_data). Synchronous active-low reset.
module chirp_spi_master_multi
  import chirp_spi_pkg::*;
#(
  parameter int  NUM_DEV  = DEF_NUM_DEV,
  parameter int  MAX_BITS = DEF_MAX_BITS,
  parameter int  DIV_W    = DEF_DIV_W,
  localparam int DEV_W    = (NUM_DEV > 1) ? $clog2(NUM_DEV) : 1,
  localparam int NB_W     = $clog2(MAX_BITS + 1)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start_tr,
  input  logic [DEV_W-1:0]    device,
  input  logic [NB_W-1:0]     num_bits,
  input  logic [DIV_W-1:0]    sclk_divider,
  input  logic                cpol,
  input  logic                cpha,
  input  logic [MAX_BITS-1:0] set_data,
`ifdef CHIRP_SPI_READBACK_EN
  input  logic                miso,
  output logic [MAX_BITS-1:0] rd_data,
`endif
  output logic                busy,
  output logic                done,
  output logic [NUM_DEV-1:0]  sen,
  output logic                sclk,
  output logic                mosi
);

  logic [2:0]          state_q, state_d;
  logic [DEV_W-1:0]    dev_q, dev_d;
  logic                cpol_q, cpol_d;
  logic                cpha_q, cpha_d;
  logic [DIV_W-1:0]    div_q, div_d;
  logic [NB_W-1:0]     nbits_q, nbits_d;
  logic [NB_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic [MAX_BITS-1:0] shift_q, shift_d;
  logic                sclk_q, sclk_d;
  logic                tick;
  logic                xfer_active;
`ifdef CHIRP_SPI_READBACK_EN
  logic [MAX_BITS-1:0] cap_q, cap_d;
  logic [MAX_BITS-1:0] rd_q, rd_d;
`endif

  assign xfer_active = (state_q == ST_LEAD) || (state_q == ST_EDGE_A) ||
                       (state_q == ST_EDGE_B) || (state_q == ST_TRAIL);

  chirp_spi_clkgen #(.DIV_W(DIV_W)) u_clkgen (
    .clock   (clock),
    .reset   (reset),
    .clear_i (state_q == ST_IDLE),
    .en_i    (xfer_active),
    .div_i   (div_q),
    .tick_o  (tick)
  );

  always_comb begin
    state_d   = state_q;
    dev_d     = dev_q;
    cpol_d    = cpol_q;
    cpha_d    = cpha_q;
    div_d     = div_q;
    nbits_d   = nbits_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    sclk_d    = sclk_q;
`ifdef CHIRP_SPI_READBACK_EN
    cap_d     = cap_q;
    rd_d      = rd_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (start_tr) begin
          dev_d     = device;
          cpol_d    = cpol;
          cpha_d    = cpha;
          div_d     = sclk_divider;
          nbits_d   = (32'(num_bits) > 32'(MAX_BITS)) ? NB_W'(MAX_BITS) : num_bits;
          bit_cnt_d = '0;
          shift_d   = set_data;
          sclk_d    = cpol;
`ifdef CHIRP_SPI_READBACK_EN
          cap_d     = '0;
`endif
          // Empty or unaddressable requests complete without touching the bus.
          state_d   = ((num_bits == '0) || (32'(device) >= 32'(NUM_DEV))) ? ST_DONE : ST_LEAD;
        end
      end
      ST_LEAD: begin
        if (tick) state_d = ST_EDGE_A;
      end
      ST_EDGE_A: begin
        if (tick) begin
          sclk_d  = ~cpol_q;
          state_d = ST_EDGE_B;
          if ((cpha_q == CPHA_SHIFT_LEAD) && (bit_cnt_q != '0)) begin
            shift_d = {shift_q[MAX_BITS-2:0], 1'b0};
          end
`ifdef CHIRP_SPI_READBACK_EN
          if (cpha_q == CPHA_SAMPLE_LEAD) cap_d = {cap_q[MAX_BITS-2:0], miso};
`endif
        end
      end
      ST_EDGE_B: begin
        if (tick) begin
          sclk_d    = cpol_q;
          bit_cnt_d = bit_cnt_q + NB_W'(1);
          state_d   = (bit_cnt_q == nbits_q - NB_W'(1)) ? ST_TRAIL : ST_EDGE_A;
          if (cpha_q == CPHA_SAMPLE_LEAD) begin
            shift_d = {shift_q[MAX_BITS-2:0], 1'b0};
          end
`ifdef CHIRP_SPI_READBACK_EN
          if (cpha_q == CPHA_SHIFT_LEAD) cap_d = {cap_q[MAX_BITS-2:0], miso};
`endif
        end
      end
      ST_TRAIL: begin
        if (tick) state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
`ifdef CHIRP_SPI_READBACK_EN
        rd_d    = cap_q;
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      dev_q     <= '0;
      cpol_q    <= CPOL_IDLE_LOW;
      cpha_q    <= CPHA_SAMPLE_LEAD;
      div_q     <= '0;
      nbits_q   <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      sclk_q    <= 1'b0;
`ifdef CHIRP_SPI_READBACK_EN
      cap_q     <= '0;
      rd_q      <= '0;
`endif
    end else begin
      state_q   <= state_d;
      dev_q     <= dev_d;
      cpol_q    <= cpol_d;
      cpha_q    <= cpha_d;
      div_q     <= div_d;
      nbits_q   <= nbits_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      sclk_q    <= sclk_d;
`ifdef CHIRP_SPI_READBACK_EN
      cap_q     <= cap_d;
      rd_q      <= rd_d;
`endif
    end
  end

  always_comb begin
    sen = '1;
    for (int i = 0; i < NUM_DEV; i++) begin
      if (xfer_active && (32'(dev_q) == 32'(i))) sen[i] = 1'b0;
    end
  end

  assign busy = (state_q != ST_IDLE);
  assign done = (state_q == ST_DONE);
  assign sclk = sclk_q;
  assign mosi = shift_q[MAX_BITS-1];
`ifdef CHIRP_SPI_READBACK_EN
  assign rd_data = rd_q;
`endif

endmodule

// File: tb/tb_chirp_spi_master_multi.sv
// Directed bench for chirp_spi_master_multi (NUM_DEV=3 so that device==NUM_DEV is representable);
// the readback step is compiled only when CHIRP_SPI_READBACK_EN is defined.
module tb_chirp_spi_master_multi;

  logic        clock = 1'b0;
  logic        reset;
  logic        start_tr;
  logic [1:0]  device;
  logic [5:0]  num_bits;
  logic [15:0] sclk_divider;
  logic        cpol;
  logic        cpha;
  logic [31:0] set_data;
  logic        busy;
  logic        done;
  logic [2:0]  sen;
  logic        sclk;
  logic        mosi;
`ifdef CHIRP_SPI_READBACK_EN
  logic        miso;
  logic [31:0] rd_data;
  logic [7:0]  slave_q;
  logic        slave_load = 1'b0;
`endif

  int errors = 0;
  int checks = 0;

  chirp_spi_master_multi #(.NUM_DEV(3), .MAX_BITS(32), .DIV_W(16)) dut (
    .clock        (clock),
    .reset        (reset),
    .start_tr     (start_tr),
    .device       (device),
    .num_bits     (num_bits),
    .sclk_divider (sclk_divider),
    .cpol         (cpol),
    .cpha         (cpha),
    .set_data     (set_data),
`ifdef CHIRP_SPI_READBACK_EN
    .miso         (miso),
    .rd_data      (rd_data),
`endif
    .busy         (busy),
    .done         (done),
    .sen          (sen),
    .sclk         (sclk),
    .mosi         (mosi)
  );

  always #5 clock = ~clock;

`ifdef CHIRP_SPI_READBACK_EN
  // Mode-0 slave: presents its MSB and shifts on each falling sclk edge.
  assign miso = slave_q[7];
  always @(negedge sclk or posedge slave_load) begin
    if (slave_load) slave_q <= 8'h3C;
    else            slave_q <= {slave_q[6:0], 1'b0};
  end
`endif

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Starts one request at a negedge, watches the bus each cycle and checks the outcome.
  task automatic run_xfer(input string tag, input logic [1:0] dev, input logic [5:0] nb,
                          input logic [15:0] dv, input logic pol, input logic pha,
                          input logic [31:0] data, input logic [2:0] exp_sen,
                          input int exp_done, input int exp_active, input int exp_edges,
                          input logic [31:0] exp_word);
    int          cyc;
    int          active;
    int          bad;
    int          edges;
    int          viol;
    logic [31:0] word;
    logic        prev_sclk;
    logic        prev_mosi;
    logic        first_sclk;
    device = dev; num_bits = nb; sclk_divider = dv; cpol = pol; cpha = pha;
    set_data = data; start_tr = 1'b1;
    @(posedge clock);
    #1 start_tr = 1'b0;
    active = 0; bad = 0; edges = 0; viol = 0; word = '0;
    prev_sclk = pol; prev_mosi = data[31]; first_sclk = 1'bx;
    for (cyc = 1; cyc <= exp_done + 20; cyc++) begin
      @(negedge clock);
      if (cyc == 1) first_sclk = sclk;
      if (sen != 3'b111) begin
        if (sen == exp_sen) active++;
        else bad++;
      end
      if (sclk && !prev_sclk) begin
        edges++;
        word = {word[30:0], mosi};
        if (mosi !== prev_mosi) viol++;
      end
      prev_sclk = sclk;
      prev_mosi = mosi;
      if (done) break;
    end
    check({tag, "_done_cycle"},  64'(cyc),        64'(exp_done));
    check({tag, "_sclk_idle"},   64'(first_sclk), 64'(pol));
    check({tag, "_sen_bad"},     64'(bad),        64'(0));
    check({tag, "_sen_cycles"},  64'(active),     64'(exp_active));
    check({tag, "_rise_edges"},  64'(edges),      64'(exp_edges));
    check({tag, "_mosi_word"},   64'(word),       64'(exp_word));
    check({tag, "_mosi_at_rise"}, 64'(viol),      64'(0));
    check({tag, "_sclk_end"},    64'(sclk),       64'(pol));
    check({tag, "_sen_end"},     64'(sen),        64'(3'b111));
    @(negedge clock);
    check({tag, "_busy_after"},  64'(busy),       64'(0));
    check({tag, "_done_pulse"},  64'(done),       64'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int dones;
    int acts;
    int first_done;
    int second_done;
    int edges;
    logic prev_act;
    logic prev_sclk;

    reset = 1'b0; start_tr = 1'b0; device = '0; num_bits = '0; sclk_divider = '0;
    cpol = 1'b0; cpha = 1'b0; set_data = '0;
    repeat (3) @(negedge clock);
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_sen",  64'(sen),  64'(3'b111));
    check("rst_sclk", 64'(sclk), 64'(0));
    check("rst_mosi", 64'(mosi), 64'(0));
`ifdef CHIRP_SPI_READBACK_EN
    check("rst_rd_data", 64'(rd_data), 64'(0));
`endif
    reset = 1'b1;
    @(negedge clock);

    // Mode 0, D=1, N=8: done at 1+18*2.
    run_xfer("t1", 2'd1, 6'd8, 16'd1, 1'b0, 1'b0, 32'hA500_0000, 3'b101, 37, 36, 8, 32'h0000_00A5);
    // Mode 3, D=0, N=16: done at 1+34.
    run_xfer("t2", 2'd2, 6'd16, 16'd0, 1'b1, 1'b1, 32'hC3A5_0000, 3'b011, 35, 34, 16, 32'h0000_C3A5);

    // start_tr held through the first transfer and into the idle cycle after done.
    device = 2'd1; num_bits = 6'd2; sclk_divider = 16'd0; cpol = 1'b0; cpha = 1'b0;
    set_data = 32'hC000_0000; start_tr = 1'b1;
    dones = 0; acts = 0; first_done = -1; second_done = -1; prev_act = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clock);
      if (done) begin
        dones++;
        if (dones == 1) first_done = c;
        else second_done = c;
      end
      if ((sen != 3'b111) && !prev_act) acts++;
      prev_act = (sen != 3'b111);
      if ((dones == 1) && busy && !done) start_tr = 1'b0;
    end
    start_tr = 1'b0;
    check("t3_done_count",  64'(dones),       64'(2));
    check("t3_sen_bursts",  64'(acts),        64'(2));
    check("t3_first_done",  64'(first_done),  64'(6));
    check("t3_second_done", 64'(second_done), 64'(14));

    // Degenerate requests finish the cycle after acceptance with a silent bus.
    run_xfer("t4_nb0",  2'd1, 6'd0, 16'd1, 1'b0, 1'b0, 32'hA500_0000, 3'b101, 1, 0, 0, 32'h0);
    run_xfer("t4_dev3", 2'd3, 6'd8, 16'd1, 1'b0, 1'b0, 32'hA500_0000, 3'b101, 1, 0, 0, 32'h0);
    // num_bits above MAX_BITS is clamped to 32 bits: done at 1+66.
    run_xfer("t4_clamp", 2'd0, 6'd40, 16'd0, 1'b0, 1'b0, 32'h5A5A_F00F, 3'b110, 67, 66, 32, 32'h5A5A_F00F);

    // Reset in the middle of a 32-bit transfer.
    device = 2'd0; num_bits = 6'd32; sclk_divider = 16'd0; cpol = 1'b0; cpha = 1'b0;
    set_data = 32'hFFFF_FFFF; start_tr = 1'b1;
    @(posedge clock);
    #1 start_tr = 1'b0;
    edges = 0; prev_sclk = 1'b0;
    for (int c = 0; (c < 100) && (edges < 5); c++) begin
      @(negedge clock);
      if (sclk && !prev_sclk) edges++;
      prev_sclk = sclk;
    end
    check("t5_edges_before_reset", 64'(edges), 64'(5));
    check("t5_busy_before_reset",  64'(busy),  64'(1));
    reset = 1'b0;
    @(negedge clock);
    check("t5_sen",  64'(sen),  64'(3'b111));
    check("t5_sclk", 64'(sclk), 64'(0));
    check("t5_busy", 64'(busy), 64'(0));
    check("t5_done", 64'(done), 64'(0));
    check("t5_mosi", 64'(mosi), 64'(0));
    reset = 1'b1;
    @(negedge clock);
    run_xfer("t5_clean", 2'd0, 6'd32, 16'd0, 1'b0, 1'b0, 32'h8000_0001, 3'b110, 67, 66, 32, 32'h8000_0001);

`ifdef CHIRP_SPI_READBACK_EN
    slave_load = 1'b1;
    #1 slave_load = 1'b0;
    run_xfer("t6", 2'd0, 6'd8, 16'd1, 1'b0, 1'b0, 32'h1200_0000, 3'b110, 37, 36, 8, 32'h0000_0012);
    check("t6_rd_data", 64'(rd_data), 64'(32'h0000_003C));
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
